ioctl_rom_loader: RTL and testbench

Parametrised ROM download steering block for arcade cores. Sits between `data_io` and the per-region `dpram` ROM/PROM banks in a core top-level. It replaces the hand-written `ioctl_addr[24:13] == k` write-enable decode with a registered, multi-region loader. It also tracks download state, per-region completion, overrun and byte count, and gates core start-up with a ready flag.

---
 rtl/ioctl_loader_pkg.sv | 13 +
 rtl/ioctl_region_decode.sv | 17 +
 rtl/ioctl_rom_loader.sv | 146 ++++++++++++++
 tb/tb_ioctl_rom_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_loader_pkg.sv
// Shared types and default geometry for the ioctl ROM loader.
package ioctl_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    localparam int DEFAULT_ADDR_W       = 25;
    localparam int DEFAULT_REGION_SHIFT = 13;

endpackage

// File: rtl/ioctl_region_decode.sv
// Combinational region decode: window number -> one-hot bank enable plus out-of-range flag.
module ioctl_region_decode #(
    parameter int NUM_REGIONS = 8,
    parameter int REGION_W    = 12
) (
    input  logic [REGION_W-1:0]    region,
    output logic [NUM_REGIONS-1:0] region_we,
    output logic                   out_of_range
);

    for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_we
        assign region_we[k] = (region == REGION_W'(k));
    end

    assign out_of_range = (32'(region) >= NUM_REGIONS);

endmodule

// File: rtl/ioctl_rom_loader.sv
// Multi-region ROM download steering with load state, status and byte count.
// Optional per-region additive checksums are built when ROM_CHECKSUM_EN is defined.
module ioctl_rom_loader
    import ioctl_loader_pkg::*;
#(
    parameter int         NUM_REGIONS  = 8,
    parameter int         ADDR_W       = DEFAULT_ADDR_W,
    parameter int         REGION_SHIFT = DEFAULT_REGION_SHIFT,
    parameter logic [7:0] INDEX        = 8'd0
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ioctl_download,
    input  logic [7:0]                ioctl_index,
    input  logic                      ioctl_wr,
    input  logic [ADDR_W-1:0]         ioctl_addr,
    input  logic [7:0]                ioctl_dout,
    output logic [NUM_REGIONS-1:0]    rom_we_o,
    output logic [REGION_SHIFT-1:0]   rom_addr_o,
    output logic [7:0]                rom_data_o,
    output logic                      rom_ready_o,
    output logic                      load_done_o,
    output logic [NUM_REGIONS-1:0]    region_loaded_o,
    output logic                      overrun_o,
    output logic [ADDR_W-1:0]         byte_count_o
`ifdef ROM_CHECKSUM_EN
    ,
    input  logic [$clog2(NUM_REGIONS)-1:0] csum_sel_i,
    output logic [7:0]                     csum_o
`endif
);

    localparam int REGION_W = ADDR_W - REGION_SHIFT;

    loader_state_t state, state_nxt;
    logic dl_q;
    logic dl_rise, enter_load, finish_load, accept;
    logic [NUM_REGIONS-1:0] region_we;
    logic region_oor;

    ioctl_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_W    (REGION_W)
    ) u_decode (
        .region       (ioctl_addr[ADDR_W-1:REGION_SHIFT]),
        .region_we    (region_we),
        .out_of_range (region_oor)
    );

    // dl_q resets high so a download already in flight at reset is not seen as a new one.
    assign dl_rise = ioctl_download && !dl_q;
    assign accept  = (state == LOAD) && ioctl_download && ioctl_wr;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            dl_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            dl_q  <= ioctl_download;
        end
    end

    always_comb begin
        state_nxt   = state;
        enter_load  = 1'b0;
        finish_load = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (dl_rise && ioctl_index == INDEX) begin
                    state_nxt  = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (!ioctl_download) begin
                    state_nxt   = DONE;
                    finish_load = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_we_o    <= '0;
            rom_addr_o  <= '0;
            rom_data_o  <= '0;
            rom_ready_o <= 1'b0;
            load_done_o <= 1'b0;
        end else begin
            rom_we_o    <= accept ? region_we : '0;
            rom_ready_o <= (state_nxt == DONE);
            load_done_o <= finish_load;
            if (accept) begin
                rom_addr_o <= ioctl_addr[REGION_SHIFT-1:0];
                rom_data_o <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || enter_load) begin
            region_loaded_o <= '0;
            overrun_o       <= 1'b0;
            byte_count_o    <= '0;
        end else if (accept) begin
            region_loaded_o <= region_loaded_o | region_we;
            if (region_oor)
                overrun_o <= 1'b1;
            if (byte_count_o != '1)
                byte_count_o <= byte_count_o + 1'b1;
        end
    end

`ifdef ROM_CHECKSUM_EN
    localparam int SEL_W = $clog2(NUM_REGIONS);

    logic [7:0]     csum_q [NUM_REGIONS];
    logic [SEL_W:0] sel_ext;

    assign sel_ext = {1'b0, csum_sel_i};

    always_ff @(posedge clk_sys) begin
        if (reset || enter_load) begin
            for (int k = 0; k < NUM_REGIONS; k++)
                csum_q[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_REGIONS; k++)
                if (region_we[k])
                    csum_q[k] <= csum_q[k] + ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            csum_o <= '0;
        else if (sel_ext < (SEL_W+1)'(NUM_REGIONS))
            csum_o <= csum_q[csum_sel_i];
        else
            csum_o <= '0;
    end
`endif

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Directed table-driven bench for ioctl_rom_loader (default geometry, 8 regions).
module tb_ioctl_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  rom_we_o;
    logic [12:0] rom_addr_o;
    logic [7:0]  rom_data_o;
    logic        rom_ready_o;
    logic        load_done_o;
    logic [7:0]  region_loaded_o;
    logic        overrun_o;
    logic [24:0] byte_count_o;
`ifdef ROM_CHECKSUM_EN
    logic [2:0]  csum_sel_i;
    logic [7:0]  csum_o;
`endif

    int total = 0;
    int bad   = 0;

    ioctl_rom_loader dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .ioctl_download  (ioctl_download),
        .ioctl_index     (ioctl_index),
        .ioctl_wr        (ioctl_wr),
        .ioctl_addr      (ioctl_addr),
        .ioctl_dout      (ioctl_dout),
        .rom_we_o        (rom_we_o),
        .rom_addr_o      (rom_addr_o),
        .rom_data_o      (rom_data_o),
        .rom_ready_o     (rom_ready_o),
        .load_done_o     (load_done_o),
        .region_loaded_o (region_loaded_o),
        .overrun_o       (overrun_o),
        .byte_count_o    (byte_count_o)
`ifdef ROM_CHECKSUM_EN
        ,
        .csum_sel_i      (csum_sel_i),
        .csum_o          (csum_o)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        dl;
        logic [7:0]  idx;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic [7:0]  we;
        logic [12:0] raddr;
        logic [7:0]  rdata;
        logic        chk_ad;
        logic        rdy;
        logic        dn;
        logic [7:0]  loaded;
        logic        ovr;
        logic [24:0] cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic dl, logic [7:0] idx, logic wr, logic [24:0] addr,
                                logic [7:0] dout, logic [7:0] we, logic [12:0] raddr,
                                logic [7:0] rdata, logic chk_ad, logic rdy, logic dn,
                                logic [7:0] loaded, logic ovr, logic [24:0] cnt);
        vec_t v;
        v.dl = dl; v.idx = idx; v.wr = wr; v.addr = addr; v.dout = dout;
        v.we = we; v.raddr = raddr; v.rdata = rdata; v.chk_ad = chk_ad;
        v.rdy = rdy; v.dn = dn; v.loaded = loaded; v.ovr = ovr; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic dl, input logic [7:0] idx, input logic wr,
                         input logic [24:0] addr, input logic [7:0] dout);
        ioctl_download = dl;
        ioctl_index    = idx;
        ioctl_wr       = wr;
        ioctl_addr     = addr;
        ioctl_dout     = dout;
    endtask

    initial begin
        //                dl idx  wr addr        dout  we     raddr     rdata ad rdy dn loaded ovr cnt
        vecs[0]  = mk(1, 8'd0, 0, 25'h0,     8'h00, 8'h00, 13'h0000, 8'h00, 1, 0, 0, 8'h00, 0, 25'd0);
        vecs[1]  = mk(1, 8'd0, 1, 25'h0000,  8'h11, 8'h01, 13'h0000, 8'h11, 1, 0, 0, 8'h01, 0, 25'd1);
        vecs[2]  = mk(1, 8'd0, 1, 25'h2001,  8'h22, 8'h02, 13'h0001, 8'h22, 1, 0, 0, 8'h03, 0, 25'd2);
        vecs[3]  = mk(1, 8'd0, 0, 25'h0,     8'h00, 8'h00, 13'h0001, 8'h22, 1, 0, 0, 8'h03, 0, 25'd2);
        vecs[4]  = mk(1, 8'd0, 1, 25'h10000, 8'h44, 8'h00, 13'h0000, 8'h00, 0, 0, 0, 8'h03, 1, 25'd3);
        vecs[5]  = mk(1, 8'd0, 1, 25'h4FFF,  8'h33, 8'h04, 13'h0FFF, 8'h33, 1, 0, 0, 8'h07, 1, 25'd4);
        vecs[6]  = mk(0, 8'd0, 1, 25'h0000,  8'h55, 8'h00, 13'h0FFF, 8'h33, 1, 1, 1, 8'h07, 1, 25'd4);
        vecs[7]  = mk(0, 8'd0, 0, 25'h0,     8'h00, 8'h00, 13'h0FFF, 8'h33, 1, 1, 0, 8'h07, 1, 25'd4);
        vecs[8]  = mk(1, 8'd1, 0, 25'h0,     8'h00, 8'h00, 13'h0FFF, 8'h33, 1, 1, 0, 8'h07, 1, 25'd4);
        vecs[9]  = mk(1, 8'd1, 1, 25'h0000,  8'h66, 8'h00, 13'h0FFF, 8'h33, 1, 1, 0, 8'h07, 1, 25'd4);
        vecs[10] = mk(0, 8'd1, 0, 25'h0,     8'h00, 8'h00, 13'h0FFF, 8'h33, 1, 1, 0, 8'h07, 1, 25'd4);
        vecs[11] = mk(1, 8'd0, 0, 25'h0,     8'h00, 8'h00, 13'h0FFF, 8'h33, 1, 0, 0, 8'h00, 0, 25'd0);
        vecs[12] = mk(1, 8'd0, 1, 25'hE005,  8'h77, 8'h80, 13'h0005, 8'h77, 1, 0, 0, 8'h80, 0, 25'd1);
        vecs[13] = mk(0, 8'd0, 0, 25'h0,     8'h00, 8'h00, 13'h0005, 8'h77, 1, 1, 1, 8'h80, 0, 25'd1);

        reset = 1'b1;
        drive(0, 8'd0, 0, 25'h0, 8'h00);
`ifdef ROM_CHECKSUM_EN
        csum_sel_i = 3'd0;
`endif
        tick();
        tick();
        chk("reset_we",     32'(rom_we_o), 32'h0);
        chk("reset_ready",  32'(rom_ready_o), 32'h0);
        chk("reset_done",   32'(load_done_o), 32'h0);
        chk("reset_loaded", 32'(region_loaded_o), 32'h0);
        chk("reset_ovr",    32'(overrun_o), 32'h0);
        chk("reset_cnt",    32'(byte_count_o), 32'h0);
        chk("reset_addr",   32'(rom_addr_o), 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].dl, vecs[i].idx, vecs[i].wr, vecs[i].addr, vecs[i].dout);
            tick();
            chk($sformatf("v%0d_we", i),     32'(rom_we_o),        32'(vecs[i].we));
            if (vecs[i].chk_ad) begin
                chk($sformatf("v%0d_addr", i), 32'(rom_addr_o),    32'(vecs[i].raddr));
                chk($sformatf("v%0d_data", i), 32'(rom_data_o),    32'(vecs[i].rdata));
            end
            chk($sformatf("v%0d_ready", i),  32'(rom_ready_o),     32'(vecs[i].rdy));
            chk($sformatf("v%0d_done", i),   32'(load_done_o),     32'(vecs[i].dn));
            chk($sformatf("v%0d_loaded", i), 32'(region_loaded_o), 32'(vecs[i].loaded));
            chk($sformatf("v%0d_ovr", i),    32'(overrun_o),       32'(vecs[i].ovr));
            chk($sformatf("v%0d_cnt", i),    32'(byte_count_o),    32'(vecs[i].cnt));
        end

        // reset in the middle of a download that stays active
        drive(1, 8'd0, 0, 25'h0, 8'h00);
        tick();
        drive(1, 8'd0, 1, 25'h0003, 8'hA5);
        tick();
        chk("mid_pre_we", 32'(rom_we_o), 32'h01);
        reset = 1'b1;
        drive(1, 8'd0, 0, 25'h0, 8'h00);
        tick();
        chk("mid_rst_we",     32'(rom_we_o), 32'h0);
        chk("mid_rst_ready",  32'(rom_ready_o), 32'h0);
        chk("mid_rst_cnt",    32'(byte_count_o), 32'h0);
        chk("mid_rst_loaded", 32'(region_loaded_o), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'd0, 1, 25'h2003 + 25'(i), 8'h10);
            tick();
            chk($sformatf("mid_drop%0d_we", i),  32'(rom_we_o), 32'h0);
            chk($sformatf("mid_drop%0d_cnt", i), 32'(byte_count_o), 32'h0);
        end
        drive(0, 8'd0, 0, 25'h0, 8'h00);
        tick();
        chk("mid_end_ready", 32'(rom_ready_o), 32'h0);
        chk("mid_end_done",  32'(load_done_o), 32'h0);

        drive(1, 8'd0, 0, 25'h0, 8'h00);
        tick();
        drive(1, 8'd0, 1, 25'h0002, 8'h5A);
        tick();
        chk("reload_we",   32'(rom_we_o), 32'h01);
        chk("reload_addr", 32'(rom_addr_o), 32'h0002);
        chk("reload_data", 32'(rom_data_o), 32'h5A);
        chk("reload_cnt",  32'(byte_count_o), 32'd1);
        drive(0, 8'd0, 0, 25'h0, 8'h00);
        tick();
        chk("reload_ready", 32'(rom_ready_o), 32'h1);
        chk("reload_done",  32'(load_done_o), 32'h1);
        tick();
        chk("reload_pulse_end", 32'(load_done_o), 32'h0);

`ifdef ROM_CHECKSUM_EN
        drive(1, 8'd0, 0, 25'h0, 8'h00);
        tick();
        drive(1, 8'd0, 1, 25'hA000, 8'hFF);
        tick();
        drive(1, 8'd0, 1, 25'hA001, 8'h02);
        tick();
        drive(1, 8'd0, 0, 25'h0, 8'h00);
        csum_sel_i = 3'd5;
        tick();
        chk("csum_r5", 32'(csum_o), 32'h01);
        csum_sel_i = 3'd0;
        tick();
        chk("csum_r0", 32'(csum_o), 32'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
